branch_update_queue: RTL
========================

BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter DEPTH, default 16, number of in-flight branch entries (power of two, >= 2).
REQ-002 Parameter PTR_W, default $clog2(DEPTH), width of entry tags and pointers.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 alloc_valid  input  1  fetch allocates one branch entry this cycle.
REQ-006 alloc_pc  input  32  branch PC.
REQ-007 alloc_pred1 / alloc_pred2 / alloc_final  input  1 each  component predictions and the chosen prediction at fetch.
REQ-008 alloc_ready  output  1  entry available for allocation (combinational).
REQ-009 alloc_tag  output  PTR_W  tag of the entry allocated this cycle (current tail index).
REQ-010 resolve_valid  input  1  execute unit resolves one branch.
REQ-011 resolve_tag  input  PTR_W  entry being resolved.
REQ-012 resolve_taken  input  1  actual direction.
REQ-013 resolve_target  input  32  actual taken target.
REQ-014 flush  input  1  discard all entries.
REQ-015 branch_commit  output  1  one-cycle pulse: predictor update valid.
REQ-016 branch_taken_pc  output  32  PC of the committing branch (predictor table index source).
REQ-017 branch_taken  output  1  actual direction of the committing branch.
REQ-018 prediction_1 / prediction_2  output  1 each  component predictions recorded at fetch for the committing branch.
REQ-019 mispredict  output  1  one-cycle pulse, coincident with branch_commit, when recorded alloc_final != actual direction.
REQ-020 redirect_pc  output  32  correct next PC, valid when mispredict=1.

Function
REQ-021 Storage SHALL be a circular buffer of DEPTH entries: valid, resolved, pc, pred1, pred2, final, taken, target; head, tail pointers and a count of PTR_W+1 bits.
REQ-022 alloc_ready SHALL equal (count != DEPTH) and SHALL NOT consider a same-cycle pop.
REQ-023 An allocation SHALL occur when alloc_valid && alloc_ready && !flush: write the entry at tail with valid=1 and resolved=0, then tail+1 modulo DEPTH.
REQ-024 alloc_valid while alloc_ready=0 SHALL be ignored with no state change.
REQ-025 A resolution SHALL occur when resolve_valid && !flush and entry[resolve_tag].valid: set resolved=1 and store taken and target.
REQ-026 Resolution of an invalid entry, or of an already-resolved entry, SHALL be ignored.
REQ-027 A pop SHALL occur when entry[head].valid && entry[head].resolved && !flush (state at cycle start): clear valid, head+1 modulo DEPTH.
REQ-028 A resolution written in cycle N SHALL make that entry eligible for pop no earlier than cycle N+1.
REQ-029 Outputs SHALL be registered: a pop in cycle N asserts branch_commit with that entry's data in cycle N+1 (latency 1); at most one pop per cycle.
REQ-030 mispredict = (final != taken); redirect_pc = taken ? target : pc + 32'd4, wrapping modulo 2^32.
REQ-031 count SHALL be +1 on allocate only, -1 on pop only, unchanged on both or neither; allocate and pop in the same cycle are both legal.
REQ-032 Commit order SHALL be strict allocation order, independent of resolution order.
REQ-033 flush SHALL take priority over same-cycle allocate, resolve and pop: next cycle all valid=0, head=tail=0, count=0, branch_commit=0, mispredict=0.
REQ-034 When branch_commit=0, branch_taken_pc, branch_taken, prediction_1, prediction_2 and redirect_pc SHALL hold their last values; mispredict SHALL be 0.

Reset
REQ-035 On rst, all entry valid and resolved bits, head, tail and count SHALL clear to 0.
REQ-036 On rst, all outputs registered in the block (branch_commit, branch_taken_pc, branch_taken, prediction_1, prediction_2, mispredict, redirect_pc) SHALL clear to 0.
REQ-037 After rst, alloc_ready=1 and alloc_tag=0; rst SHALL override flush and every other input.

Verification
REQ-038 Allocate tag0 (pc=0x100, pred1=1, pred2=0, final=0); resolve tag0 taken=1, target=0x200 -> two cycles after the resolve: branch_commit=1, branch_taken_pc=0x100, branch_taken=1, prediction_1=1, prediction_2=0, mispredict=1, redirect_pc=0x200.
REQ-039 Allocate tags 0,1,2; resolve 2, then 1, then 0 -> commits emitted for pc of tags 0,1,2 in that order, back to back.
REQ-040 Allocate DEPTH entries with no resolves -> alloc_ready=0; a further alloc_valid is ignored; resolve head -> alloc_ready=1 the cycle after the pop; tail wraps to 0.
REQ-041 Resolve a correctly predicted branch (final=1, taken=1, pc=0xFFFFFFFC) -> mispredict=0; a not-taken mispredict at the same pc gives redirect_pc=0x00000000.
REQ-042 With 3 valid entries, flush in the same cycle as allocate and resolve -> next cycle count=0, alloc_tag=0, no branch_commit in any later cycle for those entries.
REQ-043 Assert rst while entries are in flight -> next cycle all outputs 0, alloc_ready=1, and later resolves of old tags are ignored.

Source files
------------

// File: rtl/branch_update_queue.sv
// In-order branch update queue: records predictions at fetch, accepts out-of-order
// resolutions from execute, and retires entries in allocation order to update the predictor.
module branch_update_queue #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic [31:0]      alloc_pc,
    input  logic             alloc_pred1,
    input  logic             alloc_pred2,
    input  logic             alloc_final,
    output logic             alloc_ready,
    output logic [PTR_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [PTR_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic [31:0]      resolve_target,
    input  logic             flush,
    output logic             branch_commit,
    output logic [31:0]      branch_taken_pc,
    output logic             branch_taken,
    output logic             prediction_1,
    output logic             prediction_2,
    output logic             mispredict,
    output logic [31:0]      redirect_pc
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic              valid_q    [DEPTH];
    logic              resolved_q [DEPTH];
    logic [31:0]       pc_q       [DEPTH];
    logic              pred1_q    [DEPTH];
    logic              pred2_q    [DEPTH];
    logic              final_q    [DEPTH];
    logic              taken_q    [DEPTH];
    logic [31:0]       target_q   [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W:0]    count_q;

    logic do_alloc;
    logic do_resolve;
    logic do_pop;

    assign alloc_ready = (count_q != FULL);
    assign alloc_tag   = tail_q;

    // Pop looks only at start-of-cycle state, so a same-cycle resolve waits one cycle.
    always_comb begin
        do_alloc   = alloc_valid && alloc_ready && !flush;
        do_resolve = resolve_valid && !flush && valid_q[resolve_tag] && !resolved_q[resolve_tag];
        do_pop     = valid_q[head_q] && resolved_q[head_q] && !flush;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]    <= 1'b0;
                resolved_q[i] <= 1'b0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            // Alloc targets an invalid slot and pop a resolved one, so the three never collide.
            if (do_alloc) begin
                valid_q[tail_q]    <= 1'b1;
                resolved_q[tail_q] <= 1'b0;
                tail_q             <= tail_q + PTR_W'(1);
            end
            if (do_resolve) begin
                resolved_q[resolve_tag] <= 1'b1;
            end
            if (do_pop) begin
                valid_q[head_q]    <= 1'b0;
                resolved_q[head_q] <= 1'b0;
                head_q             <= head_q + PTR_W'(1);
            end
            case ({do_alloc, do_pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; the valid bits qualify it.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            pc_q[tail_q]    <= alloc_pc;
            pred1_q[tail_q] <= alloc_pred1;
            pred2_q[tail_q] <= alloc_pred2;
            final_q[tail_q] <= alloc_final;
        end
        if (do_resolve) begin
            taken_q[resolve_tag]  <= resolve_taken;
            target_q[resolve_tag] <= resolve_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_commit   <= 1'b0;
            branch_taken_pc <= '0;
            branch_taken    <= 1'b0;
            prediction_1    <= 1'b0;
            prediction_2    <= 1'b0;
            mispredict      <= 1'b0;
            redirect_pc     <= '0;
        end else begin
            branch_commit <= do_pop;
            mispredict    <= do_pop && (final_q[head_q] != taken_q[head_q]);
            if (do_pop) begin
                branch_taken_pc <= pc_q[head_q];
                branch_taken    <= taken_q[head_q];
                prediction_1    <= pred1_q[head_q];
                prediction_2    <= pred2_q[head_q];
                redirect_pc     <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
            end
        end
    end

endmodule
